// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
// Optional build macro used by mult_arbiter: MULT_ARBITER_ZERO_BYPASS_EN.
package mult_arbiter_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int DEF_NREQ  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin picker: the first active request at or after i_ptr wins.
module rr_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDXW-1:0] o_idx,
   output logic            o_any
);

   logic [IDXW-1:0] w_cand;

   // Wrap is by modulo NREQ so non-power-of-two counts skip unused indices.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = IDXW'((int'(i_ptr) + k) % NREQ);
         if (!o_any && i_req[w_cand]) begin
            o_any           = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one handshake multiplier among NREQ requesters, one operation at a time.
// Build macro MULT_ARBITER_ZERO_BYPASS_EN: zero operands skip the multiplier entirely.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       cl_req,
   input  logic [NREQ*WIDTH-1:0] cl_a,
   input  logic [NREQ*WIDTH-1:0] cl_b,
   output logic [NREQ-1:0]       cl_rdy,
   output logic [NREQ-1:0]       cl_done,
   output logic [2*WIDTH-1:0]    cl_ab,
   output logic                  m_req,
   input  logic                  m_rdy,
   output logic [WIDTH-1:0]      m_a,
   output logic [WIDTH-1:0]      m_b,
   input  logic                  m_done,
   input  logic [2*WIDTH-1:0]    m_ab
);

   localparam int IDXW = idx_width(NREQ);

   state_t               r_state;
   logic [IDXW-1:0]      r_ptr;
   logic [IDXW-1:0]      r_owner;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_res;
   logic                 r_mreq;
   logic [NREQ-1:0]      r_done;

   logic [NREQ-1:0]      w_grant;
   logic [IDXW-1:0]      w_idx;
   logic                 w_any;
   logic [WIDTH-1:0]     w_sel_a;
   logic [WIDTH-1:0]     w_sel_b;
   logic [NREQ-1:0]      w_owner_oh;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr (
      .i_req   (cl_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_sel_a    = '0;
      w_sel_b    = '0;
      w_owner_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel_a = cl_a[i*WIDTH +: WIDTH];
            w_sel_b = cl_b[i*WIDTH +: WIDTH];
         end
         if (r_owner == IDXW'(i)) begin
            w_owner_oh[i] = 1'b1;
         end
      end
   end

`ifdef MULT_ARBITER_ZERO_BYPASS_EN
   logic w_zero;
   assign w_zero = (w_sel_a == '0) || (w_sel_b == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_mreq  <= 1'b0;
         r_done  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_owner <= w_idx;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
                  if (w_zero) begin
                     r_res   <= '0;
                     r_done  <= w_grant;
                     r_state <= S_RESP;
                  end else begin
                     r_mreq  <= 1'b1;
                     r_state <= S_ISSUE;
                  end
`else
                  r_mreq  <= 1'b1;
                  r_state <= S_ISSUE;
`endif
               end
            end
            S_ISSUE: begin
               if (m_rdy) begin
                  r_mreq  <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (m_done) begin
                  r_res   <= m_ab;
                  r_done  <= w_owner_oh;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_done  <= '0;
               r_ptr   <= (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_mreq  <= 1'b0;
               r_done  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Acceptance must be visible in the granting IDLE cycle, so it is decoded, not registered.
   assign cl_rdy  = (r_state == S_IDLE && rst_n) ? w_grant : '0;
   assign cl_done = r_done;
   assign cl_ab   = r_res;
   assign m_req   = r_mreq;
   assign m_a     = r_a;
   assign m_b     = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a successive-addition multiplier model.
module tb_mult_arbiter;

   localparam int W = 5;
   localparam int N = 4;

`ifdef MULT_ARBITER_ZERO_BYPASS_EN
   localparam int   ZLAT_A0 = 1;
   localparam int   ZLAT_A7 = 1;
   localparam logic ZMREQ   = 1'b0;
`else
   localparam int   ZLAT_A0 = 3;
   localparam int   ZLAT_A7 = 10;
   localparam logic ZMREQ   = 1'b1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     cl_req;
   logic [N*W-1:0]   cl_a, cl_b;
   logic [N-1:0]     cl_rdy, cl_done;
   logic [2*W-1:0]   cl_ab;
   logic             m_req, m_rdy, m_done;
   logic [W-1:0]     m_a, m_b;
   logic [2*W-1:0]   m_ab;

   mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cl_req  (cl_req),
      .cl_a    (cl_a),
      .cl_b    (cl_b),
      .cl_rdy  (cl_rdy),
      .cl_done (cl_done),
      .cl_ab   (cl_ab),
      .m_req   (m_req),
      .m_rdy   (m_rdy),
      .m_a     (m_a),
      .m_b     (m_b),
      .m_done  (m_done),
      .m_ab    (m_ab)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Multiplier model: product appears 1+a cycles after the handshake cycle.
   logic           hs, busy, inj, saw_mreq;
   logic [W-1:0]   ha, hb;
   logic [2*W-1:0] prod;
   int             cnt;

   always @(negedge clk) begin
      hs = m_req & m_rdy;
      ha = m_a;
      hb = m_b;
   end

   always @(posedge clk) begin
      #1;
      m_done = 1'b0;
      if (!rst_n) begin
         busy = 1'b0;
      end else if (inj) begin
         m_done = 1'b1;
         m_ab   = 10'd99;
      end else if (hs && !busy) begin
         prod = '0;
         for (int k = 0; k < int'(ha); k++) prod = prod + 10'(hb);
         cnt  = int'(ha);
         busy = 1'b1;
         if (cnt == 0) begin
            m_done = 1'b1;
            m_ab   = prod;
            busy   = 1'b0;
         end
      end else if (busy) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            m_done = 1'b1;
            m_ab   = prod;
            busy   = 1'b0;
         end
      end
   end

   // Protocol monitor: one-hot pulses, done matches prior grant, result equals a*b.
   logic           pend_v;
   int             pend_i;
   logic [2*W-1:0] pend_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend_v = 1'b0;
      end else begin
         if (m_req) saw_mreq = 1'b1;
         if (cl_rdy != '0) begin
            chk("mon_rdy_onehot", 32'($onehot(cl_rdy)), 1);
            chk("mon_rdy_single_outstanding", 32'(pend_v), 0);
            for (int i = 0; i < N; i++) if (cl_rdy[i]) pend_i = i;
            pend_exp = 10'(cl_a[pend_i*W +: W]) * 10'(cl_b[pend_i*W +: W]);
            pend_v   = 1'b1;
         end
         if (cl_done != '0) begin
            chk("mon_done_onehot", 32'($onehot(cl_done)), 1);
            chk("mon_done_matches_grant", 32'(pend_v && (cl_done == N'(1 << pend_i))), 1);
            chk("mon_done_ab", 32'(cl_ab), 32'(pend_exp));
            pend_v = 1'b0;
         end
      end
   end

   task automatic run_op(input int idx, input int a, input int b, input int exp_ab,
                         input int exp_lat, input logic exp_mreq, input string nm);
      int t;
      bit got;
      @(posedge clk); #1;
      cl_req[idx]       = 1'b1;
      cl_a[idx*W +: W]  = W'(a);
      cl_b[idx*W +: W]  = W'(b);
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (cl_rdy != '0) got = 1;
      end
      chk({nm, "_grant"}, 32'(cl_rdy), 32'(1 << idx));
      t = cyc;
      saw_mreq = 1'b0;
      @(posedge clk); #1;
      cl_req[idx] = 1'b0;
      got = 0;
      for (int k = 0; k < 80 && !got; k++) begin
         @(negedge clk);
         if (cl_done != '0) got = 1;
      end
      chk({nm, "_done"}, 32'(cl_done), 32'(1 << idx));
      chk({nm, "_latency"}, 32'(cyc - t), 32'(exp_lat));
      chk({nm, "_ab"}, 32'(cl_ab), 32'(exp_ab));
      chk({nm, "_mreq_seen"}, 32'(saw_mreq), 32'(exp_mreq));
   endtask

   typedef struct {
      int   idx;
      int   a;
      int   b;
      int   exp_ab;
      int   exp_lat;
      logic exp_mreq;
   } vec_t;

   vec_t vecs[6];
   int   exp_order[5];
   int   ng, gi, di, t0;
   bit   got;

   initial begin
      rst_n = 1'b0;  cl_req = 4'hF;  cl_a = '0;  cl_b = '0;
      m_rdy = 1'b1;  m_done = 1'b0;  m_ab = '0;  inj = 1'b0;
      busy = 1'b0;   saw_mreq = 1'b0; pend_v = 1'b0; pend_i = 0;

      vecs[0] = '{0,  3,  5,  15,  6,       1'b1};
      vecs[1] = '{1,  0,  7,   0,  ZLAT_A0, ZMREQ};
      vecs[2] = '{2, 31, 31, 961, 34,       1'b1};
      vecs[3] = '{3,  1,  1,   1,  4,       1'b1};
      vecs[4] = '{1,  7,  0,   0,  ZLAT_A7, ZMREQ};
      vecs[5] = '{2,  6,  9,  54,  9,       1'b1};
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_cl_rdy", 32'(cl_rdy), 0);
      chk("reset_cl_done", 32'(cl_done), 0);
      chk("reset_m_req", 32'(m_req), 0);
      chk("reset_cl_ab", 32'(cl_ab), 0);
      chk("reset_m_a", 32'(m_a), 0);
      chk("reset_m_b", 32'(m_b), 0);
      @(posedge clk); #2;
      cl_req = '0;
      rst_n  = 1'b1;

      for (int v = 0; v < 6; v++)
         run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp_ab, vecs[v].exp_lat,
                vecs[v].exp_mreq, $sformatf("vec%0d", v));

      repeat (3) @(negedge clk);
      chk("result_hold", 32'(cl_ab), 54);

      // Completion pulse while idle must be ignored.
      @(posedge clk); #2 inj = 1'b1;
      @(posedge clk); #2 inj = 1'b0;
      @(negedge clk);
      chk("stray_mdone_no_done", 32'(cl_done), 0);
      @(negedge clk);
      chk("stray_mdone_no_done2", 32'(cl_done), 0);
      chk("stray_mdone_ab_kept", 32'(cl_ab), 54);

      // Stall in ISSUE for four cycles.
      @(posedge clk); #1;
      m_rdy = 1'b0;
      cl_req[1] = 1'b1;  cl_a[1*W +: W] = 5'd4;  cl_b[1*W +: W] = 5'd6;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (cl_rdy != '0) got = 1;
      end
      chk("stall_grant", 32'(cl_rdy), 2);
      t0 = cyc;
      @(posedge clk); #1 cl_req[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_m_req", 32'(m_req), 1);
         chk("stall_m_a", 32'(m_a), 4);
         chk("stall_m_b", 32'(m_b), 6);
         chk("stall_no_rdy", 32'(cl_rdy), 0);
      end
      @(posedge clk); #1 m_rdy = 1'b1;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (cl_done != '0) got = 1;
      end
      chk("stall_done", 32'(cl_done), 2);
      chk("stall_latency", 32'(cyc - t0), 11);
      chk("stall_ab", 32'(cl_ab), 24);

      // Reset, then all four requesting: round-robin from index 0.
      @(posedge clk); #2 rst_n = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         cl_a[i*W +: W] = 5'd1;
         cl_b[i*W +: W] = W'(i + 1);
      end
      cl_req = 4'hF;
      ng = 0;
      for (int k = 0; k < 200 && ng < 5; k++) begin
         @(negedge clk);
         if (cl_rdy != '0) begin
            for (int i = 0; i < N; i++) if (cl_rdy[i]) gi = i;
            chk("order_grant", 32'(gi), 32'(exp_order[ng]));
            ng = ng + 1;
         end
         if (cl_done != '0) begin
            for (int i = 0; i < N; i++) if (cl_done[i]) di = i;
            chk("order_ab", 32'(cl_ab), 32'(di + 1));
         end
      end
      chk("order_count", 32'(ng), 5);
      @(posedge clk); #1 cl_req = '0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (cl_done != '0) got = 1;
      end
      chk("order_last_done", 32'(cl_done), 1);

      // Reset asserted while waiting on the multiplier.
      @(posedge clk); #1;
      cl_req[2] = 1'b1;  cl_a[2*W +: W] = 5'd10;  cl_b[2*W +: W] = 5'd3;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (cl_rdy != '0) got = 1;
      end
      chk("rstwait_grant", 32'(cl_rdy), 4);
      @(posedge clk); #1 cl_req = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n  = 1'b0;
      cl_req = 4'b0110;
      #1;
      chk("rstwait_cl_rdy", 32'(cl_rdy), 0);
      chk("rstwait_cl_done", 32'(cl_done), 0);
      chk("rstwait_m_req", 32'(m_req), 0);
      chk("rstwait_cl_ab", 32'(cl_ab), 0);
      chk("rstwait_m_a", 32'(m_a), 0);
      @(posedge clk); #2;
      rst_n  = 1'b1;
      cl_req = 4'hF;
      @(negedge clk);
      chk("rstwait_first_grant", 32'(cl_rdy), 1);
      @(posedge clk); #1 cl_req = '0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (cl_done != '0) got = 1;
      end
      chk("rstwait_next_done", 32'(cl_done), 1);
      chk("rstwait_next_ab", 32'(cl_ab), 1);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
